// File: rtl/kpd_pkg.sv
// Shared keypad definitions: digit width, blank nibble and the entry-round state encoding.
package kpd_pkg;

    localparam int unsigned KPD_DIGIT_W   = 4;
    localparam logic [3:0]  KPD_BLANK     = 4'hF;
    localparam logic [3:0]  KPD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCheck,
        StDone
    } kpd_state_e;

endpackage

// File: rtl/kpd_release_detect.sv
// Synchronizes the scanner's pressed level, holds the last key code seen while pressed,
// and emits a registered one-cycle strobe on key release together with that code.
module kpd_release_detect
    import kpd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_pressed,
    input  logic [KPD_DIGIT_W-1:0] key_num,
    output logic                   release_valid,
    output logic [KPD_DIGIT_W-1:0] release_num
);

    logic                   sync1_q;
    logic                   sync2_q;
    logic                   sync2_prev_q;
    logic                   release_q;
    logic [KPD_DIGIT_W-1:0] held_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync2_prev_q <= 1'b0;
            release_q    <= 1'b0;
            held_q       <= '0;
        end else begin
            sync1_q      <= key_pressed;
            sync2_q      <= sync1_q;
            sync2_prev_q <= sync2_q;
            release_q    <= sync2_prev_q & ~sync2_q;
            if (sync2_q) begin
                held_q <= key_num;
            end
        end
    end

    assign release_valid = release_q;
    assign release_num   = held_q;

endmodule

// File: rtl/keypad_entry_controller.sv
// One code-entry round: collect DIGITS key releases, compare against the latched target.
// Optional inactivity timeout is compiled in with KPD_ENTRY_TIMEOUT_EN.
module keypad_entry_controller
    import kpd_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [KPD_DIGIT_W*DIGITS-1:0] target,
    input  logic                          key_pressed,
    input  logic [KPD_DIGIT_W-1:0]        key_num,
    output logic [KPD_DIGIT_W*DIGITS-1:0] entry,
    output logic [2:0]                    entry_count,
    output logic                          busy,
    output logic                          done,
    output logic                          match,
    output logic                          timeout
);

    localparam int unsigned W = KPD_DIGIT_W * DIGITS;

    logic                   rel_valid;
    logic [KPD_DIGIT_W-1:0] rel_num;

    kpd_release_detect u_release_detect (
        .clk           (clk),
        .rst           (rst),
        .key_pressed   (key_pressed),
        .key_num       (key_num),
        .release_valid (rel_valid),
        .release_num   (rel_num)
    );

    kpd_state_e   state_q, state_d;
    logic [W-1:0] target_q, target_d;
    logic [W-1:0] entry_q, entry_d;
    logic [2:0]   count_q, count_d;
    logic         match_q, match_d;
    logic         done_q, done_d;

`ifdef KPD_ENTRY_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimerW-1:0] timer_q, timer_d;
    logic              timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            target_q  <= '0;
            entry_q   <= {DIGITS{KPD_BLANK}};
            count_q   <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef KPD_ENTRY_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            entry_q   <= entry_d;
            count_q   <= count_d;
            match_q   <= match_d;
            done_q    <= done_d;
`ifdef KPD_ENTRY_TIMEOUT_EN
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        entry_d   = entry_q;
        count_d   = count_q;
        match_d   = match_q;
        done_d    = 1'b0;
`ifdef KPD_ENTRY_TIMEOUT_EN
        timer_d   = timer_q;
        timeout_d = timeout_q;
`endif
        // start outranks a coincident key event; a round in CHECK cannot be restarted
        if (start && state_q != StCheck) begin
            state_d  = StCollect;
            target_d = target;
            entry_d  = {DIGITS{KPD_BLANK}};
            count_d  = '0;
            match_d  = 1'b0;
`ifdef KPD_ENTRY_TIMEOUT_EN
            timer_d   = '0;
            timeout_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (rel_valid && rel_num <= KPD_MAX_DIGIT) begin
                        entry_d                = entry_q << KPD_DIGIT_W;
                        entry_d[KPD_DIGIT_W-1:0] = rel_num;
                        count_d                = count_q + 3'd1;
`ifdef KPD_ENTRY_TIMEOUT_EN
                        timer_d = '0;
`endif
                        if (count_q == 3'(DIGITS - 1)) begin
                            state_d = StCheck;
                        end
                    end
`ifdef KPD_ENTRY_TIMEOUT_EN
                    else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                        match_d   = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
                StCheck: begin
                    match_d = (entry_q == target_q);
                    state_d = StDone;
                    done_d  = 1'b1;
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    assign entry       = entry_q;
    assign entry_count = count_q;
    assign busy        = (state_q == StCollect) || (state_q == StCheck);
    assign done        = done_q;
    assign match       = match_q;
`ifdef KPD_ENTRY_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Scoreboard bench: stimulus queues the expected round result, a monitor checks it on done.
module tb_keypad_entry_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] target;
    logic        key_pressed;
    logic [3:0]  key_num;
    logic [15:0] entry;
    logic [2:0]  entry_count;
    logic        busy;
    logic        done;
    logic        match;
    logic        timeout;

    always #5 clk = ~clk;

    keypad_entry_controller #(
        .DIGITS         (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target      (target),
        .key_pressed (key_pressed),
        .key_num     (key_num),
        .entry       (entry),
        .entry_count (entry_count),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .timeout     (timeout)
    );

    typedef struct {
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic        match;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation and last one cycle.
    logic done_seen = 1'b0;
    always @(negedge clk) begin
        if (done_seen) begin
            check("done_width", {31'd0, done}, 32'd0);
            done_seen = 1'b0;
        end else if (!rst && done) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_entry", {16'd0, entry}, {16'd0, e.entry});
                check("res_count", {29'd0, entry_count}, {29'd0, e.cnt});
                check("res_match", {31'd0, match}, {31'd0, e.match});
                check("res_timeout", {31'd0, timeout}, {31'd0, e.timeout});
                check("res_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] t);
        target = t;
        start  = 1'b1;
        cycles(1);
        start  = 1'b0;
    endtask

    // Press for a few cycles, release, then allow the release pipeline to drain.
    task automatic press(input logic [3:0] k);
        key_num     = k;
        key_pressed = 1'b1;
        cycles(4);
        key_pressed = 1'b0;
        cycles(6);
    endtask

    task automatic wait_result(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
        cycles(2);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        target      = 16'h0;
        key_pressed = 1'b0;
        key_num     = 4'h0;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_entry", {16'd0, entry}, 32'h0000_FFFF);
        check("rst_count", {29'd0, entry_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);

        // Matching round, with release-to-entry latency checked on the first key
        cycles(1);
        do_start(16'h1234);
        check("start_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back('{entry: 16'h1234, cnt: 3'd4, match: 1'b1, timeout: 1'b0});
        key_num     = 4'd1;
        key_pressed = 1'b1;
        cycles(4);
        key_pressed = 1'b0;
        cycles(3);
        @(negedge clk);
        check("lat_before", {16'd0, entry}, 32'h0000_FFFF);
        @(posedge clk);
        @(negedge clk);
        check("lat_after", {16'd0, entry}, 32'h0000_FFF1);
        cycles(3);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        wait_result("round_match", 20);
        check("match_held", {31'd0, match}, 32'd1);

        // Mismatching round restarted from DONE
        do_start(16'h1234);
        check("restart_match_clr", {31'd0, match}, 32'd0);
        exp_q.push_back('{entry: 16'h1235, cnt: 3'd4, match: 1'b0, timeout: 1'b0});
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd5);
        wait_result("round_mismatch", 20);

        // Non-digit key ignored, then restart mid-round
        do_start(16'h1234);
        press(4'd1);
        press(4'hA);
        press(4'd2);
        check("nondigit_entry", {16'd0, entry}, 32'h0000_FF12);
        check("nondigit_count", {29'd0, entry_count}, 32'd2);
        do_start(16'h1234);
        press(4'd7);
        check("restart_entry", {16'd0, entry}, 32'h0000_FFF7);
        check("restart_count", {29'd0, entry_count}, 32'd1);

        // Release strobe lands on the same edge as start: start wins
        press(4'd5);
        key_num     = 4'd6;
        key_pressed = 1'b1;
        cycles(4);
        key_pressed = 1'b0;
        cycles(3);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check("coinc_entry", {16'd0, entry}, 32'h0000_FFFF);
        check("coinc_count", {29'd0, entry_count}, 32'd0);
        check("coinc_busy", {31'd0, busy}, 32'd1);
        cycles(3);
        check("coinc_after", {16'd0, entry}, 32'h0000_FFFF);

        // Reset mid-round aborts without done; releases in IDLE are dropped
        do_start(16'h1234);
        press(4'd1);
        press(4'd2);
        check("pre_rst_entry", {16'd0, entry}, 32'h0000_FF12);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("abort_entry", {16'd0, entry}, 32'h0000_FFFF);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        press(4'd3);
        check("idle_entry", {16'd0, entry}, 32'h0000_FFFF);
        check("idle_count", {29'd0, entry_count}, 32'd0);

        // Inactivity
        do_start(16'h1234);
`ifdef KPD_ENTRY_TIMEOUT_EN
        exp_q.push_back('{entry: 16'hFFFF, cnt: 3'd0, match: 1'b0, timeout: 1'b1});
        wait_result("round_timeout", 60);
        check("timeout_held", {31'd0, timeout}, 32'd1);
`else
        cycles(200);
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        check("no_timeout_flag", {31'd0, timeout}, 32'd0);
`endif

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_controller.md
# keypad_entry_controller

Sequences one code-entry round of the memorization game on top of the keypad scanner. It arms on `start` and takes key releases from the scanner's `pressed`/number interface. It collects exactly DIGITS decimal digits, compares them against the round's target code, and reports match, mismatch or inactivity timeout to the game FSM. It sits between the PmodKYPD scanner and the top-level game controller.

## Interface
- DIGITS, 4: digits per round (1–4).
- TIMEOUT_CYCLES, 100_000_000: inactivity limit in clk cycles (used only with timeout compiled in).
- clk  in  1  master clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle strobe that begins or restarts a round.
- target  in  4*DIGITS  expected code, most recent digit in bits [3:0]; sampled on start.
- key_pressed  in  1  scanner `pressed` level, asynchronous to clk domain logic.
- key_num  in  4  scanner digit code (0–9 digits, 10–15 non-digit keys).
- entry  out  4*DIGITS  digits entered so far, newest in [3:0], unfilled nibbles 4'hF.
- entry_count  out  3  digits accepted this round.
- busy  out  1  high in COLLECT and CHECK.
- done  out  1  one-cycle strobe when the round result is valid.
- match  out  1  round result; held until the next start.
- timeout  out  1  round ended by inactivity; held until the next start.

## Operation
- States: IDLE, COLLECT, CHECK, DONE. Reset → IDLE, entry=all 4'hF, entry_count=0, busy=0, done=0, match=0, timeout=0, target latch=0.
- start in IDLE, COLLECT or DONE: latch target, entry←all F, entry_count←0, match←0, timeout←0, timer←0, state→COLLECT. start in CHECK is ignored.
- key_pressed passes through a 2-flop synchronizer. key_num is captured into a hold register on every cycle the synchronized level is high. A key event is a 1→0 transition of the synchronized level (key release).
- Event in COLLECT with held digit ≤ 9: entry←{entry[4*DIGITS-5:0], digit}, entry_count+1, timer←0. Held digit ≥ 10: event dropped, timer not cleared.
- Events in IDLE, CHECK or DONE are dropped.
- Accepting the DIGITS-th digit moves the FSM COLLECT→CHECK. CHECK registers match = (entry == latched target) and moves to DONE. Entering DONE asserts done for exactly one cycle.
- DONE holds entry, match and timeout until start or rst.
- start and a key event in the same cycle: start wins and the event is discarded.
- rst mid-round aborts the round with no done pulse.

## Timing
- Raw key_pressed falling before clk edge N updates entry at edge N+3. Stages: sync1 at N, sync2 at N+1, edge detect registered at N+2, entry write at N+3.
- Last digit written at edge E: CHECK during E→E+1, DONE state and done=1 during E+1→E+2, match valid from E+1.
- start at edge S: busy=1 from S; a release synchronized before S is not counted.
- Timeout (when compiled in): timer counts cycles in COLLECT. When timer reaches TIMEOUT_CYCLES-1, the next edge goes to DONE with timeout=1, match=0, done=1. A digit accepted on that same edge takes priority and clears the timer.

## Configuration
- KPD_ENTRY_TIMEOUT_EN defined: timer and timeout path present as above.
- KPD_ENTRY_TIMEOUT_EN undefined: no timer is synthesized, timeout is tied to 0, and COLLECT waits indefinitely for digits or start.

## Structure
- Shared package kpd_pkg holds:
  - the state enum (IDLE, COLLECT, CHECK, DONE)
  - KPD_DIGIT_W=4
  - KPD_BLANK=4'hF
  - KPD_MAX_DIGIT=4'd9
- One sub-module, kpd_release_detect: 2-flop synchronizer, key_num hold register, and registered release strobe with held digit. Reused by any later keypad consumer.

## Test plan
- Reset, target=16'h1234, start, release keys 1,2,3,4 → entry=16'h1234, entry_count=4, done pulses one cycle, match=1, timeout=0.
- target=16'h1234, enter 1,2,3,5 → done pulse, match=0, entry=16'h1235.
- Enter 1, A, 2, then start, then 7 → A ignored, entry=16'hFF12 before start, then 16'hFFF7 with entry_count=1 after restart.
- Timeout enabled, TIMEOUT_CYCLES=50, start, no keys → done at cycle 51 after start, timeout=1, match=0; with macro undefined, busy stays 1.
- start and a release event on the same edge → entry=16'hFFFF, entry_count=0, busy=1.
- rst asserted after 2 digits → next cycle entry=16'hFFFF, busy=0, no done pulse; releases in IDLE leave entry unchanged.
